// File: rtl/tinytpu_pkg.sv
// Shared types and helpers for the serial matrix-multiply unit.
// Used by tinytpu_serial_mxu and tinytpu_mac.
package tinytpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    TX      = 2'd3
  } state_t;

  // Smallest result width that holds an N-term sum of D_W x D_W products
  function automatic int default_acc_w(input int d_w, input int n);
    return 2 * d_w + $clog2(n);
  endfunction

  // Bit offset of element idx inside a flattened matrix that was shifted in
  // MSB-first, row-major, so element 0 sits at the top of the vector
  function automatic int elem_offset(input int idx, input int w, input int n_elems);
    return (n_elems - 1 - idx) * w;
  endfunction

endpackage

// File: rtl/tinytpu_mac.sv
// Registered multiply-accumulate: sum = acc + a*b, acc clears after the last
// term of a dot product. Macro TINYTPU_SIGNED_EN selects two's-complement
// operands with sign-extended products; otherwise everything is unsigned.
module tinytpu_mac
  import tinytpu_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int ACC_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             last,
  input  logic [D_W-1:0]   a,
  input  logic [D_W-1:0]   b,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] prod_ext;

`ifdef TINYTPU_SIGNED_EN
  logic signed [2*D_W-1:0] a_ext;
  logic signed [2*D_W-1:0] b_ext;
  logic signed [2*D_W-1:0] prod;
  assign a_ext    = (2*D_W)'($signed(a));
  assign b_ext    = (2*D_W)'($signed(b));
  assign prod     = a_ext * b_ext;
  assign prod_ext = ACC_W'(prod);
`else
  logic [2*D_W-1:0] prod;
  assign prod     = (2*D_W)'(a) * (2*D_W)'(b);
  assign prod_ext = ACC_W'(prod);
`endif

  // Running total including this cycle's product; wraps modulo 2^ACC_W
  assign sum = acc_reg + prod_ext;

  // Hold the partial dot product; restart from zero after its last term
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/tinytpu_serial_mxu.sv
// Serial NxN matrix multiplier: shifts in X and Y bit-serially, computes
// Z = X*Y (or Z += X*Y) with one iterated MAC, then streams Z out MSB-first.
// Macro TINYTPU_SIGNED_EN (in tinytpu_mac) enables two's-complement arithmetic.
module tinytpu_serial_mxu
  import tinytpu_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int ACC_W = default_acc_w(D_W, N)
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in_x,
  input  logic data_in_y,
  input  logic load_en,
  input  logic init,
  input  logic acc_mode,
  output logic data_out_z,
  output logic tx_ready,
  output logic busy,
  output logic done
);

  localparam int NE    = N * N;
  localparam int TOTAL = NE * D_W;
  localparam int CW    = $clog2(N);
  localparam int EW    = $clog2(NE);
  localparam int BW    = $clog2(ACC_W);
  localparam int LW    = $clog2(TOTAL + 1);

  state_t           state_reg;
  logic [TOTAL-1:0] x_reg;
  logic [TOTAL-1:0] y_reg;
  logic [ACC_W-1:0] z_reg [NE];
  logic [LW-1:0]    load_cnt_reg;
  logic             loaded_reg;
  logic             acc_mode_reg;
  logic [CW-1:0]    i_reg, j_reg, k_reg;
  logic [EW-1:0]    tx_elem_reg;
  logic [BW-1:0]    tx_bit_reg;

  // Element views of the flattened operand shift registers
  logic [D_W-1:0] x_elem [NE];
  logic [D_W-1:0] y_elem [NE];
  for (genvar gi = 0; gi < NE; gi++) begin : g_elem
    assign x_elem[gi] = x_reg[elem_offset(gi, D_W, NE) +: D_W];
    assign y_elem[gi] = y_reg[elem_offset(gi, D_W, NE) +: D_W];
  end

  logic [EW-1:0]    x_idx, y_idx, z_idx;
  logic             k_last, j_last, i_last;
  logic [ACC_W-1:0] mac_sum;
  logic [EW-1:0]    tx_elem_next;
  logic [BW-1:0]    tx_bit_next;

  assign x_idx  = EW'(i_reg) * EW'(N) + EW'(k_reg);
  assign y_idx  = EW'(k_reg) * EW'(N) + EW'(j_reg);
  assign z_idx  = EW'(i_reg) * EW'(N) + EW'(j_reg);
  assign k_last = (k_reg == CW'(N - 1));
  assign j_last = (j_reg == CW'(N - 1));
  assign i_last = (i_reg == CW'(N - 1));

  assign tx_bit_next  = (tx_bit_reg == '0) ? BW'(ACC_W - 1) : tx_bit_reg - BW'(1);
  assign tx_elem_next = (tx_bit_reg == '0) ? tx_elem_reg + EW'(1) : tx_elem_reg;

  tinytpu_mac #(
    .D_W   (D_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (state_reg == COMPUTE),
    .last (k_last),
    .a    (x_elem[x_idx]),
    .b    (y_elem[y_idx]),
    .sum  (mac_sum)
  );

  // Control FSM with operand shifting, Z write-back and the Z serialiser
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      for (int e = 0; e < NE; e++) z_reg[e] <= '0;
      load_cnt_reg <= '0;
      loaded_reg   <= 1'b0;
      acc_mode_reg <= 1'b0;
      i_reg        <= '0;
      j_reg        <= '0;
      k_reg        <= '0;
      tx_elem_reg  <= '0;
      tx_bit_reg   <= '0;
      data_out_z   <= 1'b0;
      tx_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (init) begin
            state_reg    <= COMPUTE;
            busy         <= 1'b1;
            acc_mode_reg <= acc_mode;
            i_reg        <= '0;
            j_reg        <= '0;
            k_reg        <= '0;
          end else if (load_en) begin
            x_reg        <= {x_reg[TOTAL-2:0], data_in_x};
            y_reg        <= {y_reg[TOTAL-2:0], data_in_y};
            loaded_reg   <= 1'b0;
            load_cnt_reg <= LW'(1);
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          // loaded_reg is clear throughout LOAD; it guards against overrun
          if (load_en && !loaded_reg) begin
            x_reg <= {x_reg[TOTAL-2:0], data_in_x};
            y_reg <= {y_reg[TOTAL-2:0], data_in_y};
            if (load_cnt_reg == LW'(TOTAL - 1)) begin
              loaded_reg   <= 1'b1;
              load_cnt_reg <= '0;
              state_reg    <= IDLE;
            end else begin
              load_cnt_reg <= load_cnt_reg + LW'(1);
            end
          end
        end
        COMPUTE: begin
          if (k_last) begin
            z_reg[z_idx] <= acc_mode_reg ? z_reg[z_idx] + mac_sum : mac_sum;
          end
          k_reg <= k_last ? '0 : k_reg + CW'(1);
          if (k_last) j_reg <= j_last ? '0 : j_reg + CW'(1);
          if (k_last && j_last) i_reg <= i_last ? '0 : i_reg + CW'(1);
          if (k_last && j_last && i_last) begin
            // Z[0][0] was written N*N*(N-1)+... cycles ago, so it is final here
            state_reg   <= TX;
            tx_ready    <= 1'b1;
            tx_elem_reg <= '0;
            tx_bit_reg  <= BW'(ACC_W - 1);
            data_out_z  <= z_reg[0][ACC_W-1];
          end
        end
        TX: begin
          if (tx_elem_reg == EW'(NE - 1) && tx_bit_reg == '0) begin
            state_reg  <= IDLE;
            busy       <= 1'b0;
            tx_ready   <= 1'b0;
            data_out_z <= 1'b0;
            done       <= 1'b1;
          end else begin
            tx_elem_reg <= tx_elem_next;
            tx_bit_reg  <= tx_bit_next;
            data_out_z  <= z_reg[tx_elem_next][tx_bit_next];
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinytpu_serial_mxu.sv
// Scoreboard bench for tinytpu_serial_mxu: the driver pushes expected Z words
// and first-bit cycles; a monitor assembles the serial stream and compares.
module tb_tinytpu_serial_mxu;

  localparam int D_W   = 8;
  localparam int N     = 2;
  localparam int ACC_W = 17;
  localparam int NE    = N * N;
  localparam longint MASK = (64'd1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_in_x = 1'b0, data_in_y = 1'b0, load_en = 1'b0, init = 1'b0, acc_mode = 1'b0;
  logic data_out_z, tx_ready, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference state: operands and Z as plain integers
  int     mx [NE];
  int     my [NE];
  longint mz [NE];
  int     op_x [NE];
  int     op_y [NE];

  longint exp_q[$];
  int     lat_q[$];

  tinytpu_serial_mxu #(.D_W(D_W), .N(N), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in_x  (data_in_x),
    .data_in_y  (data_in_y),
    .load_en    (load_en),
    .init       (init),
    .acc_mode   (acc_mode),
    .data_out_z (data_out_z),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint sval(input int v);
`ifdef TINYTPU_SIGNED_EN
    return (v >= 128) ? longint'(v - 256) : longint'(v);
`else
    return longint'(v);
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_compute(input bit acc);
    longint s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += sval(mx[i*N+k]) * sval(my[k*N+j]);
        mz[i*N+j] = ((acc ? mz[i*N+j] : 64'sd0) + s) & MASK;
      end
  endtask

  // Shift op_x/op_y in, optionally pausing (with a stray init) before bit pause_at
  task automatic load_ops(input int pause_at, input int pause_len);
    int b = 0;
    for (int e = 0; e < NE; e++)
      for (int bi = D_W - 1; bi >= 0; bi--) begin
        if (b == pause_at && b > 0)
          for (int p = 0; p < pause_len; p++) begin
            @(posedge clk); #1;
            load_en = 1'b0; init = 1'b1;
          end
        @(posedge clk); #1;
        init = 1'b0; load_en = 1'b1;
        data_in_x = op_x[e][bi];
        data_in_y = op_y[e][bi];
        b++;
      end
    @(posedge clk); #1;
    load_en = 1'b0; data_in_x = 1'b0; data_in_y = 1'b0;
    for (int e = 0; e < NE; e++) begin mx[e] = op_x[e]; my[e] = op_y[e]; end
    $display("load: X=%0d,%0d,%0d,%0d Y=%0d,%0d,%0d,%0d pause@%0d x%0d",
             op_x[0], op_x[1], op_x[2], op_x[3], op_y[0], op_y[1], op_y[2], op_y[3], pause_at, pause_len);
  endtask

  task automatic issue_init(input bit acc, input bit with_load);
    @(posedge clk); #1;
    init = 1'b1; acc_mode = acc; load_en = with_load;
    data_in_x = 1'b1; data_in_y = 1'b1;
    lat_q.push_back(cyc + 1 + N*N*N);
    model_compute(acc);
    for (int e = 0; e < NE; e++) exp_q.push_back(mz[e]);
    $display("init: acc_mode=%0d load_en=%0d expect Z=%0d,%0d,%0d,%0d",
             acc, with_load, mz[0], mz[1], mz[2], mz[3]);
    @(posedge clk); #1;
    init = 1'b0; load_en = 1'b0; acc_mode = 1'b0; data_in_x = 1'b0; data_in_y = 1'b0;
    @(negedge clk);
    check("busy_after_init", busy, 1);
  endtask

  // Run a compute to completion while throwing junk at the ignored inputs
  task automatic do_compute(input bit acc, input bit with_load);
    bit seen = 1'b0;
    issue_init(acc, with_load);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      load_en = 1'($urandom); init = 1'($urandom); acc_mode = 1'($urandom);
      data_in_x = 1'($urandom); data_in_y = 1'($urandom);
    end
    load_en = 1'b0; init = 1'b0; acc_mode = 1'b0; data_in_x = 1'b0; data_in_y = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done, expected done within 200 cycles");
    end
  endtask

  task automatic set_ops(input int a0, a1, a2, a3, b0, b1, b2, b3);
    op_x[0] = a0; op_x[1] = a1; op_x[2] = a2; op_x[3] = a3;
    op_y[0] = b0; op_y[1] = b1; op_y[2] = b2; op_y[3] = b3;
  endtask

  // Monitor: assemble Z words from the serial stream and check timing
  initial begin
    int bits_seen = 0;
    int first_cyc = 0;
    logic [ACC_W-1:0] word = '0;
    longint e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bits_seen = 0; word = '0;
        exp_q.delete(); lat_q.delete();
      end else begin
        if (tx_ready) begin
          if (bits_seen == 0) begin
            first_cyc = cyc;
            if (lat_q.size() == 0) check("unexpected_stream", cyc, -1);
            else check("first_bit_latency", cyc, lat_q.pop_front());
          end
          word = {word[ACC_W-2:0], data_out_z};
          bits_seen++;
          if (bits_seen % ACC_W == 0) begin
            if (exp_q.size() == 0) begin
              check("z_word_unexpected", longint'(word), -1);
            end else begin
              e = exp_q.pop_front();
              check("z_word", longint'(word), e);
              $display("z[%0d] = %0d (expected %0d)", bits_seen / ACC_W - 1, word, e);
            end
          end
        end
        if (done) begin
          check("done_cycle", cyc, first_cyc + NE*ACC_W);
          check("bits_per_stream", bits_seen, NE*ACC_W);
          check("tx_ready_at_done", tx_ready, 0);
          bits_seen = 0;
        end
      end
    end
  end

  initial begin
    bit seen;
    for (int e = 0; e < NE; e++) begin mx[e] = 0; my[e] = 0; mz[e] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_data_out_z", data_out_z, 0);
    check("reset_tx_ready", tx_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Basic product, then accumulate onto it
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    load_ops(0, 0);
    do_compute(1'b0, 1'b0);
    do_compute(1'b1, 1'b0);

    // Paused load with a stray init inside LOAD
    load_ops(13, 3);
    do_compute(1'b0, 1'b0);

    // Signed-mode operands (expected values depend on the macro)
    set_ops(255, 0, 0, 255, 2, 3, 4, 5);
    load_ops(0, 0);
    do_compute(1'b0, 1'b0);

    // Largest unsigned operands
    set_ops(255, 255, 255, 255, 255, 255, 255, 255);
    load_ops(0, 0);
    do_compute(1'b0, 1'b0);

    // init wins over load_en in IDLE: operands unchanged
    do_compute(1'b0, 1'b1);

    // Randomised operands, pauses and modes
    for (int r = 0; r < 6; r++) begin
      set_ops($urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255),
              $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
      load_ops($urandom_range(31), $urandom_range(4));
      do_compute(1'($urandom), 1'b0);
    end

    // Reset in the middle of TX, then compute on cleared storage
    issue_init(1'b0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_ready) begin seen = 1'b1; break; end
    end
    check("tx_before_reset", seen, 1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("tx_ready_after_rst", tx_ready, 0);
    check("busy_after_rst", busy, 0);
    $display("reset applied during TX");
    for (int e = 0; e < NE; e++) begin mx[e] = 0; my[e] = 0; mz[e] = 0; end
    do_compute(1'b0, 1'b0);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinytpu_serial_mxu.md
Name: tinytpu_serial_mxu

Overview:
- Parametrised successor to the fixed 2x2 tinytpu core.
- Shifts in two NxN operand matrices X and Y over single-bit serial lines.
- On `init`, computes Z = X*Y (or Z += X*Y) with one iterated MAC, then streams Z out serially.
- Sits directly under the TinyTapeout wrapper, which maps its pins onto ui_in/uo_out.

Parameters:
- D_W, 8: operand element width in bits.
- N, 2: matrix dimension (NxN); N >= 2.
- ACC_W, 2*D_W+$clog2(N): result element width (17 at defaults); must be >= 2*D_W+$clog2(N).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- data_in_x  in  1  serial X bit, sampled when load_en=1.
- data_in_y  in  1  serial Y bit, sampled when load_en=1.
- load_en  in  1  operand shift enable.
- init  in  1  start-compute strobe.
- acc_mode  in  1  sampled at accepted init: 0 = overwrite Z, 1 = accumulate into Z.
- data_out_z  out  1  serial Z bit.
- tx_ready  out  1  high while data_out_z carries a valid bit.
- busy  out  1  high in COMPUTE or TX.
- done  out  1  one-cycle pulse after the last Z bit.

Behaviour:
- Reset value of every output is 0. Reset also clears the X/Y/Z storage, all counters and the loaded flag; state becomes IDLE.
- Reset mid-operation (any state) aborts; outputs are 0 on the next cycle.
- States: IDLE, LOAD, COMPUTE, TX.
- Element order is row-major; each element is shifted MSB-first. X and Y are loaded in lockstep, one bit each per cycle.
- Total load length is N*N*D_W bits.
- IDLE + init=1: go to COMPUTE. init has priority over load_en in the same cycle.
- IDLE + load_en=1: capture the bit, clear the loaded flag, set bit count to 1, go to LOAD.
- LOAD, load_en=1: capture a bit. load_en=0 pauses with count held.
- LOAD, final bit captured: set the loaded flag and return to IDLE.
- init in LOAD is ignored.
- init when loaded=0 is still accepted; it computes on the current register contents.
- load_en, init and acc_mode are ignored in COMPUTE and TX.
- COMPUTE runs counters i, j, k (k fastest) for exactly N^3 cycles. Each cycle: acc += X[i][k]*Y[k][j] at ACC_W width.
- At k=N-1, Z[i][j] receives either the sum (acc_mode=0) or Z[i][j]+sum (acc_mode=1). acc clears for the next (i,j).
- Accumulate wrap-around is modulo 2^ACC_W; there is no overflow flag.
- TX: Z streams row-major, MSB-first, ACC_W bits per element, one bit per cycle, for N*N*ACC_W cycles. tx_ready=1 throughout.
- Latency: init accepted at cycle t gives COMPUTE in cycles t+1..t+N^3. The first Z bit (Z[0][0] MSB) is valid at t+1+N^3.
- done pulses one cycle after the last bit, with tx_ready=0; state is then IDLE.
- Z persists after TX, so a later init with acc_mode=1 accumulates onto it.
- X and Y persist until reloaded or reset.

Optional Feature:
- Macro TINYTPU_SIGNED_EN.
- Defined: X and Y are two's-complement; products are sign-extended to ACC_W and Z is two's-complement.
- Undefined: all arithmetic is unsigned with zero-extension.

Decomposition:
- Package tinytpu_pkg holds:
  - the state enum typedef (IDLE/LOAD/COMPUTE/TX);
  - a function for the default ACC_W;
  - a function for the element bit offset within a flattened matrix.
- One sub-module, tinytpu_mac: a registered D_W x D_W multiply-accumulate with clear and sign-mode handling.
- The FSM, shift registers, Z storage and serialiser stay in the top module.

Test Plan:
- Basic product: N=2, load X=[[1,2],[3,4]], Y=[[5,6],[7,8]], init with acc_mode=0.
  - Response: first tx_ready at init+9 cycles.
  - Stream is 19, 22, 43, 50, each as 17 bits MSB-first.
  - done pulses 68 cycles after the first bit.
- Accumulate: repeat the basic run with acc_mode=1 and no reload. Response: 38, 44, 86, 100.
- Paused load: the same operands with load_en deasserted for 3 cycles mid-element. Response: identical output to the basic run.
- Signed mode (macro on): X=[[0xFF,0],[0,0xFF]], Y=[[2,3],[4,5]].
  - Macro on: 0x1FFFE, 0x1FFFD, 0x1FFFC, 0x1FFFB.
  - Macro off: 510, 765, 1020, 1275.
- Max unsigned: all elements 255. Response: every Z = 130050, with no truncation.
- Reset and priority:
  - rst during TX: tx_ready=0 next cycle; a following init with no load streams all-zero Z.
  - init and load_en asserted together in IDLE: COMPUTE entered and the load bit ignored.
